conv_run_sequencer: RTL and testbench



---
 rtl/conv_run_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_conv_run_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_run_sequencer.sv
// Run controller for the three 2x2 convolution engines: starts them in turn, buffers
// their results, streams the twelve results for display and cross-checks the engines.
module conv_run_sequencer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic [2:0]            eng_start,
    input  logic [2:0]            eng_done,
    input  logic [12*DATA_W-1:0]  eng_result,
    output logic [DATA_W-1:0]     display_result,
    output logic [2:0]            display_current_state,
    output logic                  busy,
    output logic                  error,
    output logic                  mismatch
);
    localparam int unsigned NUM_ENG  = 3;
    localparam int unsigned NUM_RES  = 4;
    localparam int unsigned NUM_SLOT = NUM_ENG * NUM_RES;
    localparam int unsigned IDX_W    = $clog2(NUM_SLOT);
    localparam int unsigned WAIT_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned LAST_IDX = NUM_SLOT - 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RUN_SINGLE = 3'd1,
        S_RUN_SYS3   = 3'd2,
        S_RUN_SYS2   = 3'd3,
        S_DISPLAY    = 3'd4,
        S_DONE       = 3'd5,
        S_ERR        = 3'd6
    } state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait;
    logic [IDX_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_buf [NUM_SLOT];
    logic [2:0]          r_eng_start;
    logic [DATA_W-1:0]   r_disp;
    logic                r_busy;
    logic                r_error;
    logic                r_mismatch;

    state_t              w_state_nxt;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [2:0]          w_act_mask;
    logic                w_done_seen;
    logic                w_capture;
    logic                w_mm;
    logic [2:0]          w_start_nxt;
    logic [DATA_W-1:0]   w_disp_nxt;
    logic                w_busy_nxt;
    logic                w_error_nxt;
    logic                w_mismatch_nxt;

    // One-hot mask of the engine owned by the current RUN state.
    always_comb begin
        w_act_mask = 3'b000;
        case (r_state)
            S_RUN_SINGLE: w_act_mask = 3'b001;
            S_RUN_SYS3:   w_act_mask = 3'b010;
            S_RUN_SYS2:   w_act_mask = 3'b100;
            default:      w_act_mask = 3'b000;
        endcase
    end

    // Done is ignored in the start cycle (wait counter still zero).
    assign w_done_seen = (r_wait != '0) && (|(eng_done & w_act_mask));

    // Engines disagree when any result position differs across the three entries.
    always_comb begin
        w_mm = 1'b0;
        for (int unsigned j = 0; j < NUM_RES; j++) begin
            if ((r_buf[j] != r_buf[NUM_RES + j]) || (r_buf[j] != r_buf[2*NUM_RES + j]))
                w_mm = 1'b1;
        end
    end

    // Next state plus the registered-output values for the next cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_nxt     = '0;
        w_idx_nxt      = '0;
        w_capture      = 1'b0;
        w_start_nxt    = 3'b000;
        w_disp_nxt     = '0;
        w_busy_nxt     = 1'b0;
        w_error_nxt    = r_error;
        w_mismatch_nxt = r_mismatch;

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (run) begin
                    w_state_nxt    = S_RUN_SINGLE;
                    w_error_nxt    = 1'b0;
                    w_mismatch_nxt = 1'b0;
                end
            end
            S_RUN_SINGLE, S_RUN_SYS3, S_RUN_SYS2: begin
                w_wait_nxt = r_wait + WAIT_W'(1);
                if (w_done_seen) begin
                    w_capture  = 1'b1;
                    w_wait_nxt = '0;
                    case (r_state)
                        S_RUN_SINGLE: w_state_nxt = S_RUN_SYS3;
                        S_RUN_SYS3:   w_state_nxt = S_RUN_SYS2;
                        default:      w_state_nxt = S_DISPLAY;
                    endcase
                end else if (r_wait == WAIT_W'(TIMEOUT)) begin
                    w_state_nxt = S_ERR;
                    w_wait_nxt  = '0;
                    w_error_nxt = 1'b1;
                end
            end
            S_DISPLAY: begin
                if (r_idx == IDX_W'(LAST_IDX)) begin
                    w_state_nxt    = S_DONE;
                    w_mismatch_nxt = w_mm;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        case (w_state_nxt)
            S_RUN_SINGLE: begin
                w_busy_nxt  = 1'b1;
                w_start_nxt = (r_state != S_RUN_SINGLE) ? 3'b001 : 3'b000;
            end
            S_RUN_SYS3: begin
                w_busy_nxt  = 1'b1;
                w_start_nxt = (r_state != S_RUN_SYS3) ? 3'b010 : 3'b000;
            end
            S_RUN_SYS2: begin
                w_busy_nxt  = 1'b1;
                w_start_nxt = (r_state != S_RUN_SYS2) ? 3'b100 : 3'b000;
            end
            S_DISPLAY: begin
                w_busy_nxt = 1'b1;
                w_disp_nxt = r_buf[w_idx_nxt];
            end
            S_DONE:  w_disp_nxt = r_buf[LAST_IDX];
            default: w_disp_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait      <= '0;
            r_idx       <= '0;
            r_eng_start <= 3'b000;
            r_disp      <= '0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
            r_mismatch  <= 1'b0;
            for (int unsigned i = 0; i < NUM_SLOT; i++)
                r_buf[i] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait      <= w_wait_nxt;
            r_idx       <= w_idx_nxt;
            r_eng_start <= w_start_nxt;
            r_disp      <= w_disp_nxt;
            r_busy      <= w_busy_nxt;
            r_error     <= w_error_nxt;
            r_mismatch  <= w_mismatch_nxt;
            for (int unsigned e = 0; e < NUM_ENG; e++) begin
                if (w_capture && w_act_mask[e]) begin
                    for (int unsigned j = 0; j < NUM_RES; j++)
                        r_buf[e*NUM_RES + j] <= eng_result[(e*NUM_RES + j)*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign eng_start             = r_eng_start;
    assign display_result        = r_disp;
    assign display_current_state = r_state;
    assign busy                  = r_busy;
    assign error                 = r_error;
    assign mismatch              = r_mismatch;

endmodule

// File: tb/tb_conv_run_sequencer.sv
// Bench for conv_run_sequencer: two instances (long and short timeout) driven by
// behavioural engine responders and checked cycle by cycle against a trace model.
`timescale 1ns/1ps
module tb_conv_run_sequencer;
    localparam int unsigned DW   = 8;
    localparam int unsigned TO_A = 255;
    localparam int unsigned TO_B = 8;

    typedef struct packed {
        logic [2:0] st;
        logic [2:0] start;
        logic [7:0] disp;
        logic       busy;
        logic       err;
        logic       mm;
    } obs_t;

    typedef struct {
        int         lat [3];
        logic [7:0] c22_sys2;
        logic [7:0] exp_last;
        logic       exp_mm;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_r   [2];
    logic [2:0]  done_r  [2];
    logic [95:0] res_r   [2];
    logic [2:0]  start_w [2];
    logic [7:0]  disp_w  [2];
    logic [2:0]  state_w [2];
    logic        busy_w  [2];
    logic        err_w   [2];
    logic        mm_w    [2];

    int          lat        [2][3];
    logic [2:0]  force_done [2];
    logic [7:0]  res_cfg    [2][12];
    logic [7:0]  mbuf       [2][12];
    int          cnt        [2][3];
    logic        fire_v;
    obs_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    conv_run_sequencer #(.DATA_W(DW), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .reset(reset), .run(run_r[0]), .eng_start(start_w[0]),
        .eng_done(done_r[0]), .eng_result(res_r[0]), .display_result(disp_w[0]),
        .display_current_state(state_w[0]), .busy(busy_w[0]), .error(err_w[0]),
        .mismatch(mm_w[0]));

    conv_run_sequencer #(.DATA_W(DW), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .reset(reset), .run(run_r[1]), .eng_start(start_w[1]),
        .eng_done(done_r[1]), .eng_result(res_r[1]), .display_result(disp_w[1]),
        .display_current_state(state_w[1]), .busy(busy_w[1]), .error(err_w[1]),
        .mismatch(mm_w[1]));

    // Engine responders: done pulses lat cycles after the start cycle (lat 0 = never).
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 3; e++) begin
                fire_v = 1'b0;
                if (reset) cnt[d][e] = 0;
                else if (start_w[d][e]) cnt[d][e] = lat[d][e];
                else if (cnt[d][e] > 0) begin
                    cnt[d][e] = cnt[d][e] - 1;
                    fire_v = (cnt[d][e] == 0);
                end
                done_r[d][e] = fire_v | force_done[d][e];
            end
        end
    end

    function automatic obs_t get_obs(input int d);
        return obs_t'({state_w[d], start_w[d], disp_w[d], busy_w[d], err_w[d], mm_w[d]});
    endfunction

    function automatic obs_t mk(input int st, input int sp, input logic [7:0] dp,
                                input logic b, input logic er, input logic m);
        return obs_t'({3'(st), 3'(sp), dp, b, er, m});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_results(input int d);
        for (int k = 0; k < 12; k++) res_r[d][k*8 +: 8] = res_cfg[d][k];
    endtask

    // Expected per-cycle trace from the cycle after run is sampled; also updates mbuf.
    task automatic build_model(input int d, input int to);
        logic m;
        exp_q.delete();
        for (int e = 0; e < 3; e++) begin
            if (lat[d][e] >= 1 && lat[d][e] <= to) begin
                for (int k = 0; k <= lat[d][e]; k++)
                    exp_q.push_back(mk(e + 1, (k == 0) ? (1 << e) : 0, 8'd0, 1'b1, 1'b0, 1'b0));
                for (int j = 0; j < 4; j++) mbuf[d][e*4 + j] = res_cfg[d][e*4 + j];
            end else begin
                for (int k = 0; k <= to; k++)
                    exp_q.push_back(mk(e + 1, (k == 0) ? (1 << e) : 0, 8'd0, 1'b1, 1'b0, 1'b0));
                exp_q.push_back(mk(6, 0, 8'd0, 1'b0, 1'b1, 1'b0));
                exp_q.push_back(mk(6, 0, 8'd0, 1'b0, 1'b1, 1'b0));
                return;
            end
        end
        for (int i = 0; i < 12; i++) exp_q.push_back(mk(4, 0, mbuf[d][i], 1'b1, 1'b0, 1'b0));
        m = 1'b0;
        for (int j = 0; j < 4; j++)
            if (mbuf[d][j] != mbuf[d][4 + j] || mbuf[d][j] != mbuf[d][8 + j]) m = 1'b1;
        exp_q.push_back(mk(5, 0, mbuf[d][11], 1'b0, 1'b0, m));
        exp_q.push_back(mk(5, 0, mbuf[d][11], 1'b0, 1'b0, m));
    endtask

    // Pulse run, then compare every cycle of the trace; pokes re-pulse run mid-run.
    task automatic run_and_check(input int d, input int to, input int poke1, input int poke2,
                                 input string tag);
        set_results(d);
        build_model(d, to);
        @(negedge clk); run_r[d] = 1'b1;
        @(negedge clk); run_r[d] = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("%s cyc%0d", tag, i), 32'(get_obs(d)), 32'(exp_q[i]));
            run_r[d] = (i == poke1 || i == poke2);
        end
        run_r[d] = 1'b0;
    endtask

    task automatic set_nominal(input int d, input logic [7:0] c22_sys2);
        for (int e = 0; e < 3; e++) begin
            res_cfg[d][e*4 + 0] = 8'd110;
            res_cfg[d][e*4 + 1] = 8'd101;
            res_cfg[d][e*4 + 2] = 8'd110;
            res_cfg[d][e*4 + 3] = 8'd121;
        end
        res_cfg[d][11] = c22_sys2;
    endtask

    initial begin
        vec_t tbl [3];
        int   n;
        tbl[0].lat = '{30, 20, 15}; tbl[0].c22_sys2 = 8'd121; tbl[0].exp_last = 8'd121; tbl[0].exp_mm = 1'b0;
        tbl[1].lat = '{30, 20, 15}; tbl[1].c22_sys2 = 8'd120; tbl[1].exp_last = 8'd120; tbl[1].exp_mm = 1'b1;
        tbl[2].lat = '{1, 1, 1};    tbl[2].c22_sys2 = 8'd121; tbl[2].exp_last = 8'd121; tbl[2].exp_mm = 1'b0;

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            run_r[d] = 1'b0; force_done[d] = 3'b000; res_r[d] = '0;
            for (int e = 0; e < 3; e++) begin lat[d][e] = 0; cnt[d][e] = 0; end
            for (int k = 0; k < 12; k++) begin res_cfg[d][k] = 8'd0; mbuf[d][k] = 8'd0; end
        end
        repeat (3) @(negedge clk);
        chk("reset_a", 32'(get_obs(0)), 32'(0));
        chk("reset_b", 32'(get_obs(1)), 32'(0));
        reset = 1'b0;

        // Directed table: nominal, mismatch, minimum latency.
        for (int i = 0; i < 3; i++) begin
            for (int e = 0; e < 3; e++) lat[0][e] = tbl[i].lat[e];
            set_nominal(0, tbl[i].c22_sys2);
            run_and_check(0, TO_A, -1, -1, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_state", i), 32'(state_w[0]), 32'(5));
            chk($sformatf("tbl%0d_last", i), 32'(disp_w[0]), 32'(tbl[i].exp_last));
            chk($sformatf("tbl%0d_mm", i), 32'(mm_w[0]), 32'(tbl[i].exp_mm));
        end

        // Spurious done held on all engines, including the first start cycle.
        set_nominal(0, 8'd121);
        force_done[0] = 3'b111;
        lat[0] = '{1, 1, 1};
        run_and_check(0, TO_A, -1, -1, "spur");
        force_done[0] = 3'b000;

        // run while busy: during RUN_SYS3 done cycle and mid-DISPLAY.
        run_and_check(0, TO_A, 3, 10, "busyrun");

        // Timeout on systolic3, then restart.
        for (int k = 0; k < 12; k++) res_cfg[1][k] = 8'(k + 1);
        lat[1] = '{3, 0, 2};
        run_and_check(1, TO_B, -1, -1, "tmo");
        chk("tmo_err_flag", 32'(err_w[1]), 32'(1));
        lat[1] = '{2, 3, 4};
        run_and_check(1, TO_B, -1, -1, "tmo_restart");

        // Randomised runs with latencies straddling the timeout.
        for (int r = 0; r < 24; r++) begin
            logic [7:0] base [4];
            logic       same;
            for (int e = 0; e < 3; e++) lat[1][e] = $urandom_range(1, 10);
            same = 1'($urandom_range(0, 1));
            for (int j = 0; j < 4; j++) base[j] = 8'($urandom);
            for (int k = 0; k < 12; k++) res_cfg[1][k] = same ? base[k % 4] : 8'($urandom);
            run_and_check(1, TO_B, -1, -1, $sformatf("rnd%0d", r));
        end

        // Asynchronous reset in the idx=5 DISPLAY cycle.
        lat[0] = '{1, 1, 1};
        set_nominal(0, 8'd121);
        set_results(0);
        @(negedge clk); run_r[0] = 1'b1;
        @(negedge clk); run_r[0] = 1'b0;
        n = 0;
        while (state_w[0] != 3'd4 && n < 50) begin @(negedge clk); n++; end
        chk("rst_reach_display", 32'(state_w[0]), 32'(4));
        repeat (5) @(posedge clk);
        #1 chk("rst_idx5_value", 32'(disp_w[0]), 32'(101));
        #1 reset = 1'b1;
        #1 chk("rst_async", 32'({state_w[0], disp_w[0], busy_w[0]}), 32'(0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) mbuf[0][k] = 8'd0;
        chk("rst_b_idle", 32'(state_w[1]), 32'(0));
        lat[0] = '{30, 20, 15};
        run_and_check(0, TO_A, -1, -1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
